// File: rtl/mux_nx1_par_serial.sv
// -----------------------------------------------------------------------------
// mux_nx1_par_serial
//
// N-lane parallel-to-serial multiplexer for the PHY transmit path. A frame of
// NUM_LANES lanes (DATA_W data bits + 1 valid bit each) is captured into a
// shadow register on a load cycle. The lanes are then emitted one per clock,
// lane 0 first, on a registered serial lane. While enable stays high, frames
// follow each other back to back with no gap. Dropping enable lets the current
// frame drain, after which the block returns to idle.
//
// Optional build macro: MUX_NX1_LANE_ID_EN
//   When defined, the lane_id_out port is present. It is registered alongside
//   data_out.
//
// Ports:
//   clk_4f       in   single fast clock; all logic runs on its rising edge
//   reset        in   synchronous, active-high
//   enable       in   run request; sampled only at frame boundaries
//   data_in      in   NUM_LANES*DATA_W; lane k at [k*DATA_W +: DATA_W]
//   valid_in     in   NUM_LANES; bit k is the valid bit of lane k
//   load         out  combinational; high in the cycle whose closing edge
//                     captures data_in/valid_in
//   data_out     out  registered serial data
//   valid_out    out  registered valid bit of the emitted lane
//   sof_out      out  registered; high while lane 0 is on data_out
//   lane_id_out  out  registered index of the emitted lane
//                     (only with MUX_NX1_LANE_ID_EN)
// -----------------------------------------------------------------------------
module mux_nx1_par_serial #(
    parameter int DATA_W       = 8,
    parameter int NUM_LANES    = 4,
    parameter int MASK_INVALID = 1,
    parameter int PH_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                          clk_4f,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_LANES*DATA_W-1:0]   data_in,
    input  logic [NUM_LANES-1:0]          valid_in,
    output logic                          load,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid_out,
    output logic                          sof_out
`ifdef MUX_NX1_LANE_ID_EN
    ,
    output logic [PH_W-1:0]               lane_id_out
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_LANES - 1);

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [PH_W-1:0]                phase_r;
    logic [PH_W-1:0]                phase_nxt_s;
    logic [NUM_LANES*DATA_W-1:0]    shadow_data_r;
    logic [NUM_LANES-1:0]           shadow_valid_r;
    logic                           load_s;
    logic                           emit_s;
    logic [DATA_W:0]                lane_s;
    logic [DATA_W-1:0]              lane_data_s;
    logic                           lane_valid_s;

    // Select lane 'ph' from the shadow as {data, valid}. A compare loop keeps
    // unused phase codes harmless for non-power-of-two lane counts.
    function automatic logic [DATA_W:0] pick_lane(
        input logic [NUM_LANES*DATA_W-1:0] d,
        input logic [NUM_LANES-1:0]        v,
        input logic [PH_W-1:0]             ph
    );
        logic [DATA_W:0] r;
        r = {(DATA_W + 1){1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            r = (PH_W'(k) == ph) ? {d[k*DATA_W +: DATA_W], v[k]} : r;
        end
        return r;
    endfunction

    // Next-state, next-phase and load decode for the idle/run sequencer.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        load_s      = 1'b0;
        emit_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    load_s      = 1'b1;
                    phase_nxt_s = {PH_W{1'b0}};
                    state_nxt_s = ST_RUN;
                end else begin
                    phase_nxt_s = {PH_W{1'b0}};
                end
            end
            ST_RUN: begin
                emit_s = 1'b1;
                if (phase_r != LAST_PH) begin
                    phase_nxt_s = phase_r + PH_W'(1);
                end else if (enable) begin
                    // Frame boundary with run request: reload so the next
                    // lane 0 follows the last lane on the very next edge.
                    load_s      = 1'b1;
                    phase_nxt_s = {PH_W{1'b0}};
                end else begin
                    // Frame boundary without request: drain complete.
                    phase_nxt_s = {PH_W{1'b0}};
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                phase_nxt_s = {PH_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Current-lane extraction with optional masking of invalid lanes.
    always_comb begin
        lane_s       = pick_lane(shadow_data_r, shadow_valid_r, phase_r);
        lane_data_s  = lane_s[DATA_W:1];
        lane_valid_s = lane_s[0];
        if ((MASK_INVALID != 0) && !lane_valid_s) begin
            lane_data_s = {DATA_W{1'b0}};
        end else begin
            lane_data_s = lane_s[DATA_W:1];
        end
    end

    // load is suppressed while reset is asserted so no capture is advertised.
    assign load = load_s & ~reset;

    // Sequencer state, shadow capture and registered serial outputs.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            phase_r        <= {PH_W{1'b0}};
            shadow_data_r  <= {(NUM_LANES*DATA_W){1'b0}};
            shadow_valid_r <= {NUM_LANES{1'b0}};
            data_out       <= {DATA_W{1'b0}};
            valid_out      <= 1'b0;
            sof_out        <= 1'b0;
`ifdef MUX_NX1_LANE_ID_EN
            lane_id_out    <= {PH_W{1'b0}};
`endif
        end else begin
            state_r <= state_nxt_s;
            phase_r <= phase_nxt_s;
            if (load_s) begin
                shadow_data_r  <= data_in;
                shadow_valid_r <= valid_in;
            end
            if (emit_s) begin
                data_out  <= lane_data_s;
                valid_out <= lane_valid_s;
                sof_out   <= (phase_r == {PH_W{1'b0}});
`ifdef MUX_NX1_LANE_ID_EN
                lane_id_out <= phase_r;
`endif
            end else begin
                data_out  <= {DATA_W{1'b0}};
                valid_out <= 1'b0;
                sof_out   <= 1'b0;
`ifdef MUX_NX1_LANE_ID_EN
                lane_id_out <= {PH_W{1'b0}};
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_par_serial.sv
// -----------------------------------------------------------------------------
// tb_mux_nx1_par_serial
//
// Four instances share reset/enable and one pool of lane values:
//   [0] 4 lanes, masking on   [1] 4 lanes, masking off
//   [2] 3 lanes, masking on   [3] 1 lane,  masking on
// A queue-based reference model predicts every instance each cycle. The model
// pushes a whole frame when a load is due and pops one word per edge. A
// directed vector table additionally pins instances 0/1 to hand-derived values.
// -----------------------------------------------------------------------------
module tb_mux_nx1_par_serial;

    localparam int NI = 4;
    localparam int N_LANES [NI] = '{4, 4, 3, 1};
    localparam bit MASK    [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

    logic clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    logic       reset;
    logic       enable;
    logic [7:0] lanes [4];
    logic [3:0] vbits;

    logic [31:0] din4;
    logic [23:0] din3;
    logic [7:0]  din1;
    assign din4 = {lanes[3], lanes[2], lanes[1], lanes[0]};
    assign din3 = {lanes[2], lanes[1], lanes[0]};
    assign din1 = lanes[0];

    logic       load_o  [NI];
    logic [7:0] data_o  [NI];
    logic       valid_o [NI];
    logic       sof_o   [NI];
`ifdef MUX_NX1_LANE_ID_EN
    logic [1:0] id_a, id_b, id_c;
    logic [0:0] id_d;
`endif

    mux_nx1_par_serial #(.DATA_W(8), .NUM_LANES(4), .MASK_INVALID(1)) u_4m (
        .clk_4f(clk_4f), .reset(reset), .enable(enable),
        .data_in(din4), .valid_in(vbits),
        .load(load_o[0]), .data_out(data_o[0]), .valid_out(valid_o[0]), .sof_out(sof_o[0])
`ifdef MUX_NX1_LANE_ID_EN
        , .lane_id_out(id_a)
`endif
    );

    mux_nx1_par_serial #(.DATA_W(8), .NUM_LANES(4), .MASK_INVALID(0)) u_4n (
        .clk_4f(clk_4f), .reset(reset), .enable(enable),
        .data_in(din4), .valid_in(vbits),
        .load(load_o[1]), .data_out(data_o[1]), .valid_out(valid_o[1]), .sof_out(sof_o[1])
`ifdef MUX_NX1_LANE_ID_EN
        , .lane_id_out(id_b)
`endif
    );

    mux_nx1_par_serial #(.DATA_W(8), .NUM_LANES(3), .MASK_INVALID(1)) u_3 (
        .clk_4f(clk_4f), .reset(reset), .enable(enable),
        .data_in(din3), .valid_in(vbits[2:0]),
        .load(load_o[2]), .data_out(data_o[2]), .valid_out(valid_o[2]), .sof_out(sof_o[2])
`ifdef MUX_NX1_LANE_ID_EN
        , .lane_id_out(id_c)
`endif
    );

    mux_nx1_par_serial #(.DATA_W(8), .NUM_LANES(1), .MASK_INVALID(1)) u_1 (
        .clk_4f(clk_4f), .reset(reset), .enable(enable),
        .data_in(din1), .valid_in(vbits[0:0]),
        .load(load_o[3]), .data_out(data_o[3]), .valid_out(valid_o[3]), .sof_out(sof_o[3])
`ifdef MUX_NX1_LANE_ID_EN
        , .lane_id_out(id_d)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       sof;
        logic [3:0] id;
    } word_t;

    word_t q   [NI][$];
    word_t cur [NI];
    bit    exp_load  [NI];
    bit    load_seen [NI];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // One clock: check load before the edge, advance the model, check outputs after.
    task automatic cycle();
        word_t w;
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_load[i]  = !reset && enable && (q[i].size() <= 1);
            load_seen[i] = load_o[i];
            chk("load", i, 32'(load_o[i]), 32'(exp_load[i]));
        end
        @(posedge clk_4f);
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                q[i].delete();
                cur[i] = '0;
            end else begin
                if (q[i].size() > 0) cur[i] = q[i].pop_front();
                else                 cur[i] = '0;
                if (exp_load[i]) begin
                    for (int k = 0; k < N_LANES[i]; k++) begin
                        w.valid = vbits[k];
                        w.data  = (MASK[i] && !vbits[k]) ? 8'h00 : lanes[k];
                        w.sof   = (k == 0);
                        w.id    = 4'(k);
                        q[i].push_back(w);
                    end
                end
            end
        end
        @(negedge clk_4f);
        for (int i = 0; i < NI; i++) begin
            chk("data",  i, 32'(data_o[i]),  32'(cur[i].data));
            chk("valid", i, 32'(valid_o[i]), 32'(cur[i].valid));
            chk("sof",   i, 32'(sof_o[i]),   32'(cur[i].sof));
        end
`ifdef MUX_NX1_LANE_ID_EN
        chk("lane_id", 0, 32'(id_a), 32'(cur[0].id));
        chk("lane_id", 1, 32'(id_b), 32'(cur[1].id));
        chk("lane_id", 2, 32'(id_c), 32'(cur[2].id));
        chk("lane_id", 3, 32'(id_d), 32'(cur[3].id));
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         en;
        int         pat;
        bit         e_load;
        logic [7:0] e_data;
        bit         e_valid;
        bit         e_sof;
        logic [7:0] e_data_nm;
    } vec_t;

    vec_t vecs [$];

    task automatic add_row(input bit rst, input bit en, input int pat, input bit l,
                           input logic [7:0] d, input bit v, input bit s, input logic [7:0] dn);
        vec_t r;
        r.rst = rst; r.en = en; r.pat = pat; r.e_load = l;
        r.e_data = d; r.e_valid = v; r.e_sof = s; r.e_data_nm = dn;
        vecs.push_back(r);
    endtask

    task automatic set_pat(input int pat);
        case (pat)
            0: begin lanes[0] = 8'h11; lanes[1] = 8'h22; lanes[2] = 8'h33; lanes[3] = 8'h44; vbits = 4'hF; end
            1: begin lanes[0] = 8'hA0; lanes[1] = 8'hA1; lanes[2] = 8'hA2; lanes[3] = 8'hA3; vbits = 4'hF; end
            2: begin lanes[0] = 8'hDE; lanes[1] = 8'hAD; lanes[2] = 8'hBE; lanes[3] = 8'hEF; vbits = 4'b0101; end
            default: begin lanes[0] = 8'h00; lanes[1] = 8'h00; lanes[2] = 8'h00; lanes[3] = 8'h00; vbits = 4'h0; end
        endcase
    endtask

    initial begin
        bit seen;
        reset  = 1'b1;
        enable = 1'b0;
        set_pat(0);

        //       rst en pat load data   v  sof  data(no mask)
        add_row(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);  // reset
        add_row(1, 1, 0, 0, 8'h00, 0, 0, 8'h00);  // load held low in reset
        add_row(0, 1, 0, 1, 8'h00, 0, 0, 8'h00);  // idle load of frame A
        add_row(0, 1, 0, 0, 8'h11, 1, 1, 8'h11);
        add_row(0, 1, 1, 0, 8'h22, 1, 0, 8'h22);  // data_in change ignored
        add_row(0, 1, 1, 0, 8'h33, 1, 0, 8'h33);
        add_row(0, 1, 1, 1, 8'h44, 1, 0, 8'h44);  // boundary reload of B
        add_row(0, 1, 2, 0, 8'hA0, 1, 1, 8'hA0);  // gap-free
        add_row(0, 1, 2, 0, 8'hA1, 1, 0, 8'hA1);
        add_row(0, 1, 2, 0, 8'hA2, 1, 0, 8'hA2);
        add_row(0, 1, 2, 1, 8'hA3, 1, 0, 8'hA3);  // reload of C
        add_row(0, 1, 3, 0, 8'hDE, 1, 1, 8'hDE);
        add_row(0, 1, 3, 0, 8'h00, 0, 0, 8'hAD);  // masked invalid lane
        add_row(0, 0, 3, 0, 8'hBE, 1, 0, 8'hBE);  // enable dropped mid-frame
        add_row(0, 0, 3, 0, 8'h00, 0, 0, 8'hEF);  // drain lane 3
        add_row(0, 0, 3, 0, 8'h00, 0, 0, 8'h00);  // back in idle
        add_row(0, 0, 3, 0, 8'h00, 0, 0, 8'h00);
        add_row(0, 1, 0, 1, 8'h00, 0, 0, 8'h00);
        add_row(0, 1, 0, 0, 8'h11, 1, 1, 8'h11);
        add_row(0, 1, 0, 0, 8'h22, 1, 0, 8'h22);
        add_row(0, 1, 0, 0, 8'h33, 1, 0, 8'h33);
        add_row(1, 1, 0, 0, 8'h00, 0, 0, 8'h00);  // reset while lane 2 shown
        add_row(0, 1, 0, 1, 8'h00, 0, 0, 8'h00);
        add_row(0, 0, 0, 0, 8'h11, 1, 1, 8'h11);  // fresh frame starts at lane 0
        add_row(0, 0, 0, 0, 8'h22, 1, 0, 8'h22);
        add_row(0, 0, 0, 0, 8'h33, 1, 0, 8'h33);
        add_row(0, 0, 0, 0, 8'h44, 1, 0, 8'h44);
        add_row(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);

        for (int r = 0; r < vecs.size(); r++) begin
            reset  = vecs[r].rst;
            enable = vecs[r].en;
            set_pat(vecs[r].pat);
            cycle();
            chk("tbl_load",    r, 32'(load_seen[0]), 32'(vecs[r].e_load));
            chk("tbl_data",    r, 32'(data_o[0]),    32'(vecs[r].e_data));
            chk("tbl_valid",   r, 32'(valid_o[0]),   32'(vecs[r].e_valid));
            chk("tbl_sof",     r, 32'(sof_o[0]),     32'(vecs[r].e_sof));
            chk("tbl_data_nm", r, 32'(data_o[1]),    32'(vecs[r].e_data_nm));
        end

        // Randomized traffic: occasional resets, mostly-on enable, random lanes.
        for (int c = 0; c < 400; c++) begin
            reset  = ($urandom_range(0, 99) < 3);
            enable = ($urandom_range(0, 99) < 80);
            for (int k = 0; k < 4; k++) lanes[k] = 8'($urandom);
            vbits = 4'($urandom);
            cycle();
        end

        // Bounded wait for the 3-lane instance to start a frame after reset.
        reset  = 1'b1;
        enable = 1'b1;
        cycle();
        reset = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            cycle();
            seen = sof_o[2];
        end
        chk("sof3_timeout", 2, 32'(seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
